// File: rtl/fib_pkg.sv
// Shared defaults and FSM state encoding for the Fibonacci RAM writer.
package fib_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned DEPTH_DEF  = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RDBK  = 2'd2,
    DONE  = 2'd3
  } fib_state_e;

endpackage

// File: rtl/fib_step.sv
// Two-term Fibonacci history with a carry-out adder; seed loads (f0,f1), adv steps one term.
module fib_step
  import fib_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed,
  input  logic              adv,
  output logic [DATA_W-1:0] cur,
  output logic              cur_cy
);

  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] cur_q;
  logic              cy_q;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, prev_q} + {1'b0, cur_q};

  // cy_q remembers whether the term now in cur_q was produced with a carry-out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      cur_q  <= '0;
      cy_q   <= 1'b0;
    end else if (seed) begin
      prev_q <= '0;
      cur_q  <= DATA_W'(1);
      cy_q   <= 1'b0;
    end else if (adv) begin
      prev_q <= cur_q;
      cur_q  <= sum[DATA_W-1:0];
      cy_q   <= sum[DATA_W];
    end
  end

  assign cur    = cur_q;
  assign cur_cy = cy_q;

endmodule

// File: rtl/fibonacci_ram_writer.sv
// Fills a RAM with the Fibonacci sequence; optional readback verify when FIB_READBACK_EN is defined.
module fibonacci_ram_writer
  import fib_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wren,
  output logic [ADDR_W-1:0] wradr,
  output logic [DATA_W-1:0] wrdat,
  output logic              ovf,
  output logic [ADDR_W-1:0] rdadr,
  input  logic [DATA_W-1:0] rddat,
  output logic              err,
  output logic [ADDR_W-1:0] err_adr
);

  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  fib_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              seed, adv;
  logic [DATA_W-1:0] fib_cur;
  logic              fib_cy;
  logic              busy_d, done_d, wren_d, ovf_d;
  logic [ADDR_W-1:0] wradr_d;
  logic [DATA_W-1:0] wrdat_d;

`ifdef FIB_READBACK_EN
  logic [ADDR_W-1:0] rdadr_d, err_adr_d;
  logic              err_d;
  logic [DATA_W-1:0] val_q, val_d;
`endif

  fib_step #(.DATA_W(DATA_W)) u_step (
    .clk    (clk),
    .rst    (rst),
    .seed   (seed),
    .adv    (adv),
    .cur    (fib_cur),
    .cur_cy (fib_cy)
  );

  // Next-state and next-output logic; outputs are registered one edge later
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed    = 1'b0;
    adv     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wren_d  = 1'b0;
    wradr_d = '0;
    wrdat_d = '0;
    ovf_d   = ovf;
`ifdef FIB_READBACK_EN
    rdadr_d   = '0;
    err_d     = err;
    err_adr_d = err_adr;
    val_d     = val_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          cnt_d   = '0;
          seed    = 1'b1;
          busy_d  = 1'b1;
          wren_d  = 1'b1;
          ovf_d   = 1'b0;
`ifdef FIB_READBACK_EN
          err_d     = 1'b0;
          err_adr_d = '0;
          val_d     = '0;
`endif
        end
      end
      WRITE: begin
        if (cnt_q == LAST_ADR) begin
`ifdef FIB_READBACK_EN
          state_d = RDBK;
          cnt_d   = '0;
          seed    = 1'b1;
          busy_d  = 1'b1;
          val_d   = '0;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          adv     = 1'b1;
          busy_d  = 1'b1;
          wren_d  = 1'b1;
          wradr_d = cnt_d;
          wrdat_d = fib_cur;
          ovf_d   = ovf | fib_cy;
`ifdef FIB_READBACK_EN
          val_d   = fib_cur;
`endif
        end
      end
`ifdef FIB_READBACK_EN
      RDBK: begin
        // rdadr equals cnt_q here, so the first mismatch address is cnt_q
        if ((rddat != val_q) && !err) begin
          err_d     = 1'b1;
          err_adr_d = cnt_q;
        end
        if (cnt_q == LAST_ADR) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          adv     = 1'b1;
          busy_d  = 1'b1;
          rdadr_d = cnt_d;
          val_d   = fib_cur;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wren    <= 1'b0;
      wradr   <= '0;
      wrdat   <= '0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      wren    <= wren_d;
      wradr   <= wradr_d;
      wrdat   <= wrdat_d;
      ovf     <= ovf_d;
    end
  end

`ifdef FIB_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdadr   <= '0;
      err     <= 1'b0;
      err_adr <= '0;
      val_q   <= '0;
    end else begin
      rdadr   <= rdadr_d;
      err     <= err_d;
      err_adr <= err_adr_d;
      val_q   <= val_d;
    end
  end
`else
  logic unused_rddat;
  assign unused_rddat = ^rddat;
  assign rdadr        = '0;
  assign err          = 1'b0;
  assign err_adr      = '0;
`endif

endmodule

// File: tb/tb_fibonacci_ram_writer.sv
// Randomized self-checking bench for fibonacci_ram_writer against a plain-arithmetic Fibonacci model.
module tb_fibonacci_ram_writer;

  localparam int D_DEF = 36;
  localparam int D_OVF = 16;
  localparam int D_MIN = 2;
`ifdef FIB_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance (24/24/36) with a RAM model that can corrupt address 7
  logic start = 1'b0, busy, done, wren, ovf, err;
  logic [23:0] wradr, rdadr, err_adr, wrdat, rddat;
  logic [23:0] mem [0:63];
  bit corrupt = 1'b0;

  // overflow instance (DATA_W=8, DEPTH=16) and minimum-depth instance (DEPTH=2), ideal RAMs
  logic o_start = 1'b0, o_busy, o_done, o_wren, o_ovf, o_err;
  logic [23:0] o_wradr, o_rdadr, o_err_adr;
  logic [7:0]  o_wrdat, o_rddat;
  logic m_start = 1'b0, m_busy, m_done, m_wren, m_ovf, m_err;
  logic [23:0] m_wradr, m_rdadr, m_err_adr, m_wrdat, m_rddat;

  fibonacci_ram_writer u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .wren(wren),
    .wradr(wradr), .wrdat(wrdat), .ovf(ovf), .rdadr(rdadr), .rddat(rddat),
    .err(err), .err_adr(err_adr));

  fibonacci_ram_writer #(.DATA_W(8), .DEPTH(D_OVF)) u_ovf (
    .clk(clk), .rst(rst), .start(o_start), .busy(o_busy), .done(o_done), .wren(o_wren),
    .wradr(o_wradr), .wrdat(o_wrdat), .ovf(o_ovf), .rdadr(o_rdadr), .rddat(o_rddat),
    .err(o_err), .err_adr(o_err_adr));

  fibonacci_ram_writer #(.DEPTH(D_MIN)) u_min (
    .clk(clk), .rst(rst), .start(m_start), .busy(m_busy), .done(m_done), .wren(m_wren),
    .wradr(m_wradr), .wrdat(m_wrdat), .ovf(m_ovf), .rdadr(m_rdadr), .rddat(m_rddat),
    .err(m_err), .err_adr(m_err_adr));

  // exact Fibonacci term, then reduced to w bits
  function automatic longint unsigned fib_exact(input int n);
    longint unsigned a = 0, b = 1, t;
    if (n == 0) return 0;
    for (int i = 1; i < n; i++) begin
      t = a + b; a = b; b = t;
    end
    return b;
  endfunction

  function automatic longint unsigned fib_mod(input int n, input int w);
    return fib_exact(n) & ((64'd1 << w) - 64'd1);
  endfunction

  // true once any term up to index n no longer fits in w bits
  function automatic bit ovf_by(input int n, input int w);
    for (int m = 0; m <= n; m++) if (fib_exact(m) >= (64'd1 << w)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) if (wren) mem[wradr[5:0]] <= wrdat;
  always_comb begin
    rddat = mem[rdadr[5:0]];
    if (corrupt && rdadr == 24'd7) rddat = mem[rdadr[5:0]] - 24'd1;
  end
  always_comb o_rddat = 8'(fib_mod(int'(o_rdadr), 8));
  always_comb m_rddat = 24'(fib_mod(int'(m_rdadr), 24));

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done got %0b want 0", done); end
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset wren got %0b want 0", wren); end
    checks++; if (wradr !== 24'd0) begin errors++; $display("FAIL reset wradr got %0d want 0", wradr); end
    checks++; if (wrdat !== 24'd0) begin errors++; $display("FAIL reset wrdat got %0d want 0", wrdat); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf got %0b want 0", ovf); end
    checks++; if (rdadr !== 24'd0) begin errors++; $display("FAIL reset rdadr got %0d want 0", rdadr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err got %0b want 0", err); end
    checks++; if (err_adr !== 24'd0) begin errors++; $display("FAIL reset err_adr got %0d want 0", err_adr); end
    checks++; if ({o_busy, o_wren, m_busy, m_wren} !== 4'b0) begin errors++; $display("FAIL reset aux busy/wren got %b want 0000", {o_busy, o_wren, m_busy, m_wren}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // one full pass on the default instance; ign_a >= 0 adds stray starts mid-pass, a start in DONE is always tried
  task automatic test_fill(input int ign_a, input bit corr, input string nm);
    int total, ign_b;
    logic [23:0] e_wradr, e_wrdat, e_rdadr, e_eadr;
    logic e_wren, e_busy, e_done, e_ovf, e_err;
    total = RB ? 2 * D_DEF : D_DEF;
    ign_b = (ign_a >= 0) ? int'($urandom_range(8, total)) : -1;
    corrupt = corr;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= total + 2; j++) begin
      e_wren  = (j <= D_DEF);
      e_wradr = e_wren ? 24'(j - 1) : 24'd0;
      e_wrdat = e_wren ? 24'(fib_mod(j - 1, 24)) : 24'd0;
      e_busy  = (j <= total);
      e_done  = (j == total + 1);
      e_ovf   = ovf_by((j <= D_DEF) ? j - 1 : D_DEF - 1, 24);
      e_rdadr = (RB && j > D_DEF && j <= 2 * D_DEF) ? 24'(j - D_DEF - 1) : 24'd0;
      e_err   = RB && corr && (j >= D_DEF + 9);
      e_eadr  = e_err ? 24'd7 : 24'd0;
      checks++; if (wren !== e_wren) begin errors++; $display("FAIL %s wren cyc=%0d got %0b want %0b", nm, j, wren, e_wren); end
      checks++; if (wradr !== e_wradr) begin errors++; $display("FAIL %s wradr cyc=%0d got %0d want %0d", nm, j, wradr, e_wradr); end
      checks++; if (wrdat !== e_wrdat) begin errors++; $display("FAIL %s wrdat cyc=%0d got %0d want %0d", nm, j, wrdat, e_wrdat); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL %s busy cyc=%0d got %0b want %0b", nm, j, busy, e_busy); end
      checks++; if (done !== e_done) begin errors++; $display("FAIL %s done cyc=%0d got %0b want %0b", nm, j, done, e_done); end
      checks++; if (ovf !== e_ovf) begin errors++; $display("FAIL %s ovf cyc=%0d got %0b want %0b", nm, j, ovf, e_ovf); end
      checks++; if (rdadr !== e_rdadr) begin errors++; $display("FAIL %s rdadr cyc=%0d got %0d want %0d", nm, j, rdadr, e_rdadr); end
      checks++; if (err !== e_err) begin errors++; $display("FAIL %s err cyc=%0d got %0b want %0b", nm, j, err, e_err); end
      checks++; if (err_adr !== e_eadr) begin errors++; $display("FAIL %s err_adr cyc=%0d got %0d want %0d", nm, j, err_adr, e_eadr); end
      start = (j == ign_a + 1) || (j == ign_b) || (j == total + 1);
      @(negedge clk);
    end
    start = 1'b0;
    corrupt = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if ({wren, wradr} !== {1'b1, 24'd10}) begin errors++; $display("FAIL rst_mid pre wren/wradr got %0b/%0d want 1/10", wren, wradr); end
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid done got %0b want 0", done); end
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL rst_mid wren got %0b want 0", wren); end
    checks++; if (wradr !== 24'd0) begin errors++; $display("FAIL rst_mid wradr got %0d want 0", wradr); end
    checks++; if (wrdat !== 24'd0) begin errors++; $display("FAIL rst_mid wrdat got %0d want 0", wrdat); end
    checks++; if ({ovf, err, rdadr, err_adr} !== 50'd0) begin errors++; $display("FAIL rst_mid ovf/err/rdadr/err_adr got %0b/%0b/%0d/%0d want 0", ovf, err, rdadr, err_adr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++; if ({busy, wren} !== 2'b00) begin errors++; $display("FAIL rst_mid resume cyc=%0d busy/wren got %b want 00", j, {busy, wren}); end
    end
  endtask

  task automatic test_overflow();
    int total;
    logic [7:0] e_dat;
    logic e_wren, e_ovf;
    total = RB ? 2 * D_OVF : D_OVF;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    o_start = 1'b1;
    @(negedge clk);
    o_start = 1'b0;
    for (int j = 1; j <= total + 1; j++) begin
      e_wren = (j <= D_OVF);
      e_dat  = e_wren ? 8'(fib_mod(j - 1, 8)) : 8'd0;
      e_ovf  = ovf_by(e_wren ? j - 1 : D_OVF - 1, 8);
      checks++; if (o_wren !== e_wren) begin errors++; $display("FAIL ovf wren cyc=%0d got %0b want %0b", j, o_wren, e_wren); end
      checks++; if (o_wradr !== (e_wren ? 24'(j - 1) : 24'd0)) begin errors++; $display("FAIL ovf wradr cyc=%0d got %0d", j, o_wradr); end
      checks++; if (o_wrdat !== e_dat) begin errors++; $display("FAIL ovf wrdat cyc=%0d got %0d want %0d", j, o_wrdat, e_dat); end
      checks++; if (o_ovf !== e_ovf) begin errors++; $display("FAIL ovf flag cyc=%0d got %0b want %0b", j, o_ovf, e_ovf); end
      checks++; if (o_done !== (j == total + 1)) begin errors++; $display("FAIL ovf done cyc=%0d got %0b want %0b", j, o_done, j == total + 1); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL ovf err cyc=%0d got %0b want 0", j, o_err); end
      @(negedge clk);
    end
  endtask

  task automatic test_min_depth();
    int total;
    logic e_wren;
    total = RB ? 2 * D_MIN : D_MIN;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int j = 1; j <= total + 2; j++) begin
      e_wren = (j <= D_MIN);
      checks++; if (m_wren !== e_wren) begin errors++; $display("FAIL min wren cyc=%0d got %0b want %0b", j, m_wren, e_wren); end
      checks++; if (m_wradr !== (e_wren ? 24'(j - 1) : 24'd0)) begin errors++; $display("FAIL min wradr cyc=%0d got %0d", j, m_wradr); end
      checks++; if (m_wrdat !== (e_wren ? 24'(fib_mod(j - 1, 24)) : 24'd0)) begin errors++; $display("FAIL min wrdat cyc=%0d got %0d", j, m_wrdat); end
      checks++; if (m_busy !== (j <= total)) begin errors++; $display("FAIL min busy cyc=%0d got %0b want %0b", j, m_busy, j <= total); end
      checks++; if (m_done !== (j == total + 1)) begin errors++; $display("FAIL min done cyc=%0d got %0b want %0b", j, m_done, j == total + 1); end
      checks++; if ({m_ovf, m_err, m_err_adr} !== 26'd0) begin errors++; $display("FAIL min ovf/err/err_adr cyc=%0d got %0b/%0b/%0d want 0", j, m_ovf, m_err, m_err_adr); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fill(-1, 1'b0, "fill");
    test_fill(5, 1'b0, "ignore");
    test_reset_mid();
    test_overflow();
    test_min_depth();
`ifdef FIB_READBACK_EN
    test_fill(-1, 1'b1, "rdbk_err");
    test_fill(-1, 1'b0, "rdbk_clean");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
